// File: rtl/stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stall_ctrl_pkg
// Brief   : Shared stall vectors, FSM states and watchdog constants.
// Revision: 1.0 - initial release
// ============================================================================
package stall_ctrl_pkg;

  // Per-stage hold vectors: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM,
  // bit4 MEM/WB, bit5 WB; a set bit holds that stage.
  localparam logic [5:0] c_stall_none       = 6'b000000;
  localparam logic [5:0] c_stall_from_id_if = 6'b000111;
  localparam logic [5:0] c_stall_from_ex    = 6'b001111;
  localparam logic [5:0] c_stall_from_mem   = 6'b011111;

  localparam int unsigned c_wdt_cnt_w      = 11;
  localparam int unsigned c_stall_timeout  = 1024;
  localparam logic [31:0] c_wdt_vector     = 32'hBFC00380;
  // Expiry is flagged on the stalled cycle whose increment would hit the timeout.
  localparam logic [c_wdt_cnt_w-1:0] c_wdt_last = c_wdt_cnt_w'(c_stall_timeout - 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  function automatic logic [5:0] stall_prio(
    input logic i_mem,
    input logic i_ex,
    input logic i_id,
    input logic i_if
  );
    if (i_mem)     return c_stall_from_mem;
    else if (i_ex) return c_stall_from_ex;
    else if (i_id) return c_stall_from_id_if;
    else if (i_if) return c_stall_from_id_if;
    else           return c_stall_none;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stall_wdt.sv
`default_nettype none
// ============================================================================
// Module  : stall_wdt
// Brief   : Consecutive-stall watchdog counter with single-cycle expiry pulse.
// Revision: 1.0 - initial release
// ============================================================================
module stall_wdt
  import stall_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_stalled,
  output logic o_expire
);

  logic [c_wdt_cnt_w-1:0] r_cnt;
  logic                   w_count;

  assign w_count  = i_run & i_stalled;
  assign o_expire = w_count && (r_cnt == c_wdt_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!w_count || o_expire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : stall_ctrl
// Brief   : Pipeline stall/flush controller with saturating stall counter.
//           Define STALL_WATCHDOG_EN to build in the stall watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module stall_ctrl
  import stall_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic        flush_req_i,
  input  logic [31:0] flush_pc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles_o,
  output logic        wdt_timeout_o
);

  state_t      r_state;
  logic        r_flush;
  logic [31:0] r_new_pc;
  logic [31:0] r_stall_cycles;
  logic [5:0]  w_stall;
  logic        w_run;
  logic        w_stalled;
  logic        w_expire;

  assign w_run = (r_state == ST_RUN);

  // Combinational so the requesting cycle itself is held; forced idle in reset.
  always_comb begin
    w_stall = c_stall_none;
    if (!rst && w_run) begin
      w_stall = stall_prio(stallreq_from_mem, stallreq_from_ex,
                           stallreq_from_id, stallreq_from_if);
    end
  end

  assign w_stalled = |w_stall;

`ifdef STALL_WATCHDOG_EN
  logic r_wdt_timeout;

  stall_wdt u_wdt (
    .clk       (clk),
    .rst       (rst),
    .i_run     (w_run),
    .i_stalled (w_stalled),
    .o_expire  (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdt_timeout <= 1'b0;
    end else if (w_expire) begin
      r_wdt_timeout <= 1'b1;
    end
  end

  assign wdt_timeout_o = r_wdt_timeout;
`else
  assign w_expire      = 1'b0;
  assign wdt_timeout_o = 1'b0;
`endif

  // Watchdog expiry outranks an external flush request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_flush  <= 1'b0;
      r_new_pc <= 32'h0;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_expire) begin
            r_state  <= ST_FLUSH;
            r_flush  <= 1'b1;
            r_new_pc <= c_wdt_vector;
          end else if (flush_req_i) begin
            r_state  <= ST_FLUSH;
            r_flush  <= 1'b1;
            r_new_pc <= flush_pc_i;
          end
        end
        ST_FLUSH: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= 32'h0;
    end else if (w_stalled && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall          = w_stall;
  assign flush          = r_flush;
  assign new_pc         = r_new_pc;
  assign stall_cycles_o = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_stall_ctrl
// Brief   : Directed self-checking bench for stall_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_stall_ctrl;

  logic        clk;
  logic        rst;
  logic        req_if;
  logic        req_id;
  logic        req_ex;
  logic        req_mem;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
  logic        wdt_timeout;

  int n_vec = 0;
  int n_err = 0;

  stall_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_if  (req_if),
    .stallreq_from_id  (req_id),
    .stallreq_from_ex  (req_ex),
    .stallreq_from_mem (req_mem),
    .flush_req_i       (flush_req),
    .flush_pc_i        (flush_pc),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .stall_cycles_o    (stall_cycles),
    .wdt_timeout_o     (wdt_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; checks follow 1 time unit later.
  task automatic drive(input logic r, input logic [3:0] req,
                       input logic fr, input logic [31:0] pc);
    @(negedge clk);
    rst       = r;
    req_mem   = req[3];
    req_ex    = req[2];
    req_id    = req[1];
    req_if    = req[0];
    flush_req = fr;
    flush_pc  = pc;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req_if = 1'b1; req_id = 1'b1; req_ex = 1'b1; req_mem = 1'b1;
    flush_req = 1'b0; flush_pc = 32'h0;

    // Reset with every request high
    drive(1'b1, 4'hF, 1'b0, 32'h0);
    drive(1'b1, 4'hF, 1'b0, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_cnt", stall_cycles, 32'h0);
    chk("rst_wdt", 32'(wdt_timeout), 32'h0);

    drive(1'b0, 4'h0, 1'b0, 32'h0);
    chk("idle_stall", 32'(stall), 32'h0);

    // Priority: id+mem, then drop mem, then ex, then if
    drive(1'b0, 4'b1010, 1'b0, 32'h0);
    chk("prio_id_mem", 32'(stall), 32'h1F);
    drive(1'b0, 4'b0010, 1'b0, 32'h0);
    chk("prio_id", 32'(stall), 32'h07);
    drive(1'b0, 4'b0110, 1'b0, 32'h0);
    chk("prio_ex_id", 32'(stall), 32'h0F);
    drive(1'b0, 4'b0001, 1'b0, 32'h0);
    chk("prio_if", 32'(stall), 32'h07);
    drive(1'b0, 4'b0000, 1'b0, 32'h0);
    chk("prio_none", 32'(stall), 32'h0);
    chk("cnt_after_prio", stall_cycles, 32'd4);

    // Counter: 5 stalled, 3 idle, 2 stalled from a fresh reset
    drive(1'b1, 4'h0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) drive(1'b0, 4'b1000, 1'b0, 32'h0);
    drive(1'b0, 4'h0, 1'b0, 32'h0);
    chk("cnt_5", stall_cycles, 32'd5);
    drive(1'b0, 4'h0, 1'b0, 32'h0);
    drive(1'b0, 4'h0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) drive(1'b0, 4'b0010, 1'b0, 32'h0);
    drive(1'b0, 4'h0, 1'b0, 32'h0);
    chk("cnt_7", stall_cycles, 32'd7);

    // Flush coincident with an EX stall
    drive(1'b0, 4'b0100, 1'b1, 32'h0000_0020);
    chk("fl_req_stall", 32'(stall), 32'h0F);
    chk("fl_req_flush", 32'(flush), 32'h0);
    drive(1'b0, 4'b1000, 1'b1, 32'h0000_0044);
    chk("fl_pulse", 32'(flush), 32'h1);
    chk("fl_new_pc", new_pc, 32'h0000_0020);
    chk("fl_stall_zero", 32'(stall), 32'h0);
    drive(1'b0, 4'h0, 1'b0, 32'h0);
    chk("fl_end", 32'(flush), 32'h0);
    chk("fl_pc_hold", new_pc, 32'h0000_0020);
    chk("fl_cnt", stall_cycles, 32'd8);

    // Reset arriving during the flush pulse
    drive(1'b0, 4'h0, 1'b1, 32'h0000_0055);
    drive(1'b1, 4'h0, 1'b0, 32'h0);
    drive(1'b0, 4'h0, 1'b0, 32'h0);
    chk("rstfl_flush", 32'(flush), 32'h0);
    chk("rstfl_new_pc", new_pc, 32'h0);
    chk("rstfl_cnt", stall_cycles, 32'h0);

    // Saturation from a preloaded near-max count
    force dut.r_stall_cycles = 32'hFFFF_FFFD;
    #1;
    release dut.r_stall_cycles;
    drive(1'b0, 4'b1000, 1'b0, 32'h0);
    drive(1'b0, 4'b1000, 1'b0, 32'h0);
    chk("sat_fe", stall_cycles, 32'hFFFF_FFFE);
    drive(1'b0, 4'b1000, 1'b0, 32'h0);
    drive(1'b0, 4'b1000, 1'b0, 32'h0);
    drive(1'b0, 4'h0, 1'b0, 32'h0);
    chk("sat_hold", stall_cycles, 32'hFFFF_FFFF);

    // Watchdog: MEM stall held for 1024 cycles
    drive(1'b1, 4'h0, 1'b0, 32'h0);
    for (int i = 0; i < 1023; i++) drive(1'b0, 4'b1000, 1'b0, 32'h0);
    drive(1'b0, 4'b1000, 1'b0, 32'h0);
    chk("wdt_pre_flush", 32'(flush), 32'h0);
    chk("wdt_pre_flag", 32'(wdt_timeout), 32'h0);
    drive(1'b0, 4'b1000, 1'b0, 32'h0);
`ifdef STALL_WATCHDOG_EN
    chk("wdt_flush", 32'(flush), 32'h1);
    chk("wdt_new_pc", new_pc, 32'hBFC0_0380);
    chk("wdt_flag", 32'(wdt_timeout), 32'h1);
    chk("wdt_stall", 32'(stall), 32'h0);
`else
    chk("wdt_flush", 32'(flush), 32'h0);
    chk("wdt_new_pc", new_pc, 32'h0);
    chk("wdt_flag", 32'(wdt_timeout), 32'h0);
    chk("wdt_stall", 32'(stall), 32'h1F);
`endif
    drive(1'b0, 4'h0, 1'b0, 32'h0);
    drive(1'b0, 4'h0, 1'b0, 32'h0);
    chk("wdt_post_flush", 32'(flush), 32'h0);
`ifdef STALL_WATCHDOG_EN
    chk("wdt_sticky", 32'(wdt_timeout), 32'h1);
`else
    chk("wdt_sticky", 32'(wdt_timeout), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
